// File: rtl/any1_issue_queue.sv
// rtl/any1_issue_queue.sv - in-order issue FIFO between scheduler and execute unit
//
// Purpose:
//   Captures one scheduler selection (ROB slot id) per cycle into a small
//   in-order FIFO, presents the head to the execute unit with valid/ready,
//   reports each accepted slot back to the ROB, drops duplicate selections
//   (counted), and back-pressures the scheduler when nearly full.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 pipeline flush, empties the queue next cycle
//   sel[6:0]              bit6=1: no selection, [5:0]: ROB id
//   sel_branch            selected slot is a branch
//   exe_ready             execute unit accepts the head this cycle
//   issue_v/id/branch     head entry
//   out_set_v/id          registered "mark out" report toward the ROB
//   hold                  scheduler back-pressure (count >= DEPTH-1)
//   count                 occupancy
//   dup_cnt               saturating count of dropped duplicate selections
module any1_issue_queue #(
  parameter int ROB_ENTRIES = 32,
  parameter int DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [6:0]                 sel,
  input  logic                       sel_branch,
  input  logic                       exe_ready,
  output logic                       issue_v,
  output logic [5:0]                 issue_id,
  output logic                       issue_branch,
  output logic                       out_set_v,
  output logic [5:0]                 out_set_id,
  output logic                       hold,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [15:0]                dup_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [6:0] ROB_LIMIT = 7'(ROB_ENTRIES);

  logic [5:0]       id_mem [DEPTH];
  logic [DEPTH-1:0] br_mem;
  logic [DEPTH-1:0] vld;     // per-slot occupancy, used only for duplicate search
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  logic [5:0] cand_id;
  logic       candidate;
  logic       hit;
  logic       dup;
  logic       pop;
  logic       push;
  logic       full;

  assign cand_id   = sel[5:0];
  assign candidate = !sel[6] && ({1'b0, sel[5:0]} < ROB_LIMIT);
  assign full      = (count == CW'(DEPTH));

  // The previous cycle's accepted id is still a duplicate: the ROB "out" bit
  // for it becomes visible to the scheduler one cycle late.
  always_comb begin
    hit = out_set_v && (out_set_id == cand_id);
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (id_mem[i] == cand_id)) hit = 1'b1;
    end
  end

  assign dup  = candidate && hit;
  assign pop  = issue_v && exe_ready && !flush;
  // Full-without-pop rejection is a plain drop; the scheduler re-selects later.
  assign push = candidate && !dup && !flush && (!full || pop);

  assign issue_v      = (count != '0);
  assign issue_id     = id_mem[rd_ptr];
  assign issue_branch = br_mem[rd_ptr];
  assign hold         = (count >= CW'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) id_mem[i] <= '0;
      br_mem     <= '0;
      vld        <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      out_set_v  <= 1'b0;
      out_set_id <= '0;
    end else if (flush) begin
      vld       <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_set_v <= 1'b0;
    end else begin
      // Clear on pop before set on push: at full, both hit the same slot.
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      if (push) begin
        id_mem[wr_ptr] <= cand_id;
        br_mem[wr_ptr] <= sel_branch;
        vld[wr_ptr]    <= 1'b1;
        wr_ptr         <= wr_ptr + 1'b1;
        out_set_id     <= cand_id;
      end
      out_set_v <= push;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dup_cnt <= '0;
    end else if (dup && !flush && (dup_cnt != 16'hFFFF)) begin
      dup_cnt <= dup_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_any1_issue_queue.sv
// tb/tb_any1_issue_queue.sv - self-checking bench for any1_issue_queue
module tb_any1_issue_queue;

  localparam int ROBN = 32;
  localparam int DEP  = 4;

  logic       clk = 0;
  logic       rst_n = 0;
  logic       flush = 0;
  logic [6:0] sel = 7'h40;
  logic       sel_branch = 0;
  logic       exe_ready = 0;
  logic       issue_v;
  logic [5:0] issue_id;
  logic       issue_branch;
  logic       out_set_v;
  logic [5:0] out_set_id;
  logic       hold;
  logic [2:0] count;
  logic [15:0] dup_cnt;

  int checks = 0;
  int errors = 0;

  // reference model: queue of {branch, id}, last report, duplicate count
  logic [6:0] q[$];
  bit         m_out_v;
  int         m_out_id;
  int         m_dup;

  any1_issue_queue #(.ROB_ENTRIES(ROBN), .DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .sel(sel), .sel_branch(sel_branch),
    .exe_ready(exe_ready), .issue_v(issue_v), .issue_id(issue_id),
    .issue_branch(issue_branch), .out_set_v(out_set_v), .out_set_id(out_set_id),
    .hold(hold), .count(count), .dup_cnt(dup_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_out_v  = 0;
    m_out_id = 0;
    m_dup    = 0;
  endtask

  // Drive one cycle of inputs, advance the model, clock, settle 1 time unit.
  task automatic step(input logic [6:0] s, input logic br, input logic rdy, input logic fl);
    bit cand, dupf, popf, pushf;
    int id;
    sel = s; sel_branch = br; exe_ready = rdy; flush = fl;
    id    = int'(s[5:0]);
    cand  = !s[6] && (id < ROBN);
    dupf  = 0;
    foreach (q[i]) if (int'(q[i][5:0]) == id) dupf = 1;
    if (m_out_v && m_out_id == id) dupf = 1;
    dupf  = dupf && cand;
    popf  = (q.size() != 0) && rdy && !fl;
    pushf = cand && !dupf && !fl && (q.size() < DEP || popf);
    if (dupf && !fl && m_dup < 65535) m_dup++;
    if (fl) begin
      q.delete();
      m_out_v = 0;
    end else begin
      if (popf) void'(q.pop_front());
      if (pushf) begin
        q.push_back({br, s[5:0]});
        m_out_id = id;
      end
      m_out_v = pushf;
    end
    @(posedge clk);
    #1;
    sel = 7'h40; flush = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    #12;
    checks++; if (issue_v !== 1'b0) begin errors++; $display("FAIL reset_issue_v got %0b want 0", issue_v); end
    checks++; if (issue_id !== 6'd0) begin errors++; $display("FAIL reset_issue_id got %0d want 0", issue_id); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (hold !== 1'b0 || out_set_v !== 1'b0 || dup_cnt !== 16'd0)
      begin errors++; $display("FAIL reset_misc got hold=%0b osv=%0b dup=%0d want 0,0,0", hold, out_set_v, dup_cnt); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    step(7'h05, 0, 1, 0);
    checks++; if (issue_v !== 1'b1 || issue_id !== 6'd5)
      begin errors++; $display("FAIL single_issue got v=%0b id=%0d want 1,5", issue_v, issue_id); end
    checks++; if (out_set_v !== 1'b1 || out_set_id !== 6'd5)
      begin errors++; $display("FAIL single_outset got v=%0b id=%0d want 1,5", out_set_v, out_set_id); end
    step(7'h40, 0, 1, 0);
    checks++; if (issue_v !== 1'b0 || count !== 3'd0)
      begin errors++; $display("FAIL single_drain got v=%0b cnt=%0d want 0,0", issue_v, count); end
  endtask

  task automatic test_fill_order();
    int d0;
    for (int k = 1; k <= 4; k++) begin
      step(7'(k), 1'(k & 1), 0, 0);
      checks++; if (count !== 3'(k) || hold !== (k >= 3))
        begin errors++; $display("FAIL fill_count got cnt=%0d hold=%0b want %0d,%0b", count, hold, k, k >= 3); end
    end
    d0 = int'(dup_cnt);
    step(7'd6, 0, 0, 0);
    checks++; if (count !== 3'd4 || int'(dup_cnt) !== d0 || out_set_v !== 1'b0)
      begin errors++; $display("FAIL full_drop got cnt=%0d dup=%0d osv=%0b want 4,%0d,0", count, dup_cnt, out_set_v, d0); end
    for (int k = 1; k <= 4; k++) begin
      checks++; if (issue_v !== 1'b1 || issue_id !== 6'(k) || issue_branch !== 1'(k & 1))
        begin errors++; $display("FAIL drain_order got v=%0b id=%0d br=%0b want 1,%0d,%0b", issue_v, issue_id, issue_branch, k, k & 1); end
      step(7'h40, 0, 1, 0);
    end
  endtask

  task automatic test_full_pushpop();
    int exp_ids[4] = '{11, 12, 13, 7};
    for (int k = 10; k <= 13; k++) step(7'(k), 0, 0, 0);
    step(7'd7, 1, 1, 0);
    checks++; if (count !== 3'd4 || out_set_v !== 1'b1)
      begin errors++; $display("FAIL full_pushpop got cnt=%0d osv=%0b want 4,1", count, out_set_v); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (issue_id !== 6'(exp_ids[k]))
        begin errors++; $display("FAIL pushpop_order got %0d want %0d", issue_id, exp_ids[k]); end
      step(7'h40, 0, 1, 0);
    end
  endtask

  task automatic test_dup();
    int d0;
    d0 = int'(dup_cnt);
    step(7'd9, 0, 0, 0);
    checks++; if (out_set_v !== 1'b1) begin errors++; $display("FAIL dup_first got osv=%0b want 1", out_set_v); end
    step(7'd9, 0, 0, 0);
    checks++; if (out_set_v !== 1'b0 || count !== 3'd1 || int'(dup_cnt) !== d0 + 1)
      begin errors++; $display("FAIL dup_second got osv=%0b cnt=%0d dup=%0d want 0,1,%0d", out_set_v, count, dup_cnt, d0 + 1); end
    step(7'h40, 0, 1, 0);
  endtask

  task automatic test_flush();
    step(7'd20, 0, 0, 0);
    step(7'd21, 0, 0, 0);
    step(7'd22, 0, 0, 0);
    step(7'd8, 0, 1, 1);
    checks++; if (count !== 3'd0 || issue_v !== 1'b0 || out_set_v !== 1'b0)
      begin errors++; $display("FAIL flush got cnt=%0d v=%0b osv=%0b want 0,0,0", count, issue_v, out_set_v); end
    step(7'h40, 0, 1, 0);
    checks++; if (issue_v !== 1'b0) begin errors++; $display("FAIL flush_after got v=%0b want 0", issue_v); end
  endtask

  task automatic test_ignore();
    int d0;
    d0 = int'(dup_cnt);
    step(7'h40, 0, 1, 0);
    step(7'h28, 0, 1, 0);
    step(7'h3F, 1, 1, 0);
    checks++; if (count !== 3'd0 || out_set_v !== 1'b0 || int'(dup_cnt) !== d0)
      begin errors++; $display("FAIL ignore got cnt=%0d osv=%0b dup=%0d want 0,0,%0d", count, out_set_v, dup_cnt, d0); end
  endtask

  task automatic test_random();
    logic [6:0] s;
    for (int c = 0; c < 300; c++) begin
      case ($urandom_range(0, 9))
        0:       s = 7'h40 | 7'($urandom_range(0, 63));
        1:       s = 7'($urandom_range(32, 63));
        default: s = 7'($urandom_range(0, 31));
      endcase
      step(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0));
      checks++;
      if (issue_v !== (q.size() != 0) || count !== 3'(q.size()) || hold !== (q.size() >= DEP - 1) ||
          (q.size() != 0 && {issue_branch, issue_id} !== q[0]) ||
          out_set_v !== m_out_v || (m_out_v && int'(out_set_id) !== m_out_id) || int'(dup_cnt) !== m_dup) begin
        errors++;
        $display("FAIL random c=%0d got v=%0b id=%0d br=%0b cnt=%0d hold=%0b osv=%0b osid=%0d dup=%0d want cnt=%0d head=%h osv=%0b osid=%0d dup=%0d",
                 c, issue_v, issue_id, issue_branch, count, hold, out_set_v, out_set_id, dup_cnt,
                 q.size(), (q.size() != 0) ? q[0] : 7'h0, m_out_v, m_out_id, m_dup);
      end
    end
  endtask

  task automatic test_async_reset();
    step(7'd3, 0, 0, 0);
    step(7'd4, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    model_reset();
    checks++; if (count !== 3'd0 || issue_v !== 1'b0 || out_set_v !== 1'b0 || dup_cnt !== 16'd0 || issue_id !== 6'd0)
      begin errors++; $display("FAIL async_reset got cnt=%0d v=%0b osv=%0b dup=%0d id=%0d want all 0", count, issue_v, out_set_v, dup_cnt, issue_id); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    step(7'd12, 0, 1, 0);
    checks++; if (issue_v !== 1'b1 || issue_id !== 6'd12)
      begin errors++; $display("FAIL post_reset got v=%0b id=%0d want 1,12", issue_v, issue_id); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_order();
    test_full_pushpop();
    test_dup();
    test_flush();
    test_ignore();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
